// File: rtl/bit_serial_mac.sv
// Bit-serial multiply-accumulate: dot product of N weights with N activations,
// one activation bit-plane per cycle (MSB first), with optional cross-vector accumulation.
module bit_serial_mac #(
  parameter int N       = 16,
  parameter int WW      = 3,
  parameter int AW      = 4,
  parameter int ACC_EXT = 4,
  localparam int PW     = WW + $clog2(N + 1),
  localparam int OW     = WW + AW + $clog2(N + 1) + ACC_EXT
) (
  input  logic           CLK,
  input  logic           reset_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic           acc_clear,
  input  logic [N*WW-1:0] weights,
  input  logic [N*AW-1:0] acts,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [OW-1:0]  out,
  output logic           busy
);

  // The dot product of one vector never exceeds PW + AW bits.
  localparam int DW = PW + AW;
  localparam int KW = (AW > 1) ? $clog2(AW) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state, state_nxt;
  logic [N*WW-1:0] w_q;
  logic [N*AW-1:0] a_q;
  logic            clr_q;
  logic [DW-1:0]   dot, dot_nxt;
  logic [KW-1:0]   k;
  logic [PW-1:0]   psum;
  logic            accept;

  assign accept  = in_valid && (state == IDLE);
  assign dot_nxt = (dot << 1) + DW'(psum);

  // NOTE: every variable written here gets a default first, so no latch is inferred.
  always_comb begin
    psum = '0;
    for (int i = 0; i < N; i++) begin
      if (a_q[i*AW + int'(k)]) psum = psum + PW'(w_q[i*WW +: WW]);
    end
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) state_nxt = RUN;
      end
      RUN:  if (k == '0) state_nxt = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: all state is reset, including the operand latches, so no X reaches the outputs.
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      w_q   <= '0;
      a_q   <= '0;
      clr_q <= 1'b0;
      dot   <= '0;
      k     <= '0;
      out   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state <= state_nxt;
      if (accept) begin
        w_q   <= weights;
        a_q   <= acts;
        clr_q <= acc_clear;
        dot   <= '0;
        k     <= KW'(AW - 1);
      end else if (state == RUN) begin
        dot <= dot_nxt;
        k   <= k - KW'(1);
        // Last bit-plane: fold the finished dot into the running result, wrapping at OW bits.
        if (k == '0) out <= (clr_q ? '0 : out) + OW'(dot_nxt);
      end
    end
  end

endmodule

// File: tb/tb_bit_serial_mac.sv
// Self-checking bench for bit_serial_mac: directed cases plus randomized vectors
// compared against an arithmetic dot-product/accumulate model.
module tb_bit_serial_mac;

  localparam int N   = 16;
  localparam int WW  = 3;
  localparam int AW  = 4;
  localparam int CW  = $clog2(N + 1);
  localparam int OW  = WW + AW + CW + 4;
  localparam int OW2 = WW + AW + CW;

  logic            CLK = 1'b0;
  logic            reset_n = 1'b0;
  logic            in_valid = 1'b0;
  logic            acc_clear = 1'b0;
  logic            out_ready = 1'b0;
  logic [N*WW-1:0] weights = '0;
  logic [N*AW-1:0] acts = '0;
  logic            in_ready, out_valid, busy;
  logic            in_ready2, out_valid2, busy2;
  logic [OW-1:0]   out;
  logic [OW2-1:0]  out2;

  int tests = 0;
  int fails = 0;

  bit_serial_mac #(.N(N), .WW(WW), .AW(AW), .ACC_EXT(4)) dut (
    .CLK(CLK), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .acc_clear(acc_clear), .weights(weights), .acts(acts), .out_valid(out_valid),
    .out_ready(out_ready), .out(out), .busy(busy)
  );

  // Narrow-result instance driven in lockstep, used to see the result wrap.
  bit_serial_mac #(.N(N), .WW(WW), .AW(AW), .ACC_EXT(0)) dut_wrap (
    .CLK(CLK), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready2),
    .acc_clear(acc_clear), .weights(weights), .acts(acts), .out_valid(out_valid2),
    .out_ready(out_ready), .out(out2), .busy(busy2)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [N*WW-1:0] all_w(input int v);
    logic [N*WW-1:0] r;
    for (int i = 0; i < N; i++) r[i*WW +: WW] = WW'(v);
    return r;
  endfunction

  function automatic logic [N*AW-1:0] all_a(input int v);
    logic [N*AW-1:0] r;
    for (int i = 0; i < N; i++) r[i*AW +: AW] = AW'(v);
    return r;
  endfunction

  function automatic logic [N*WW-1:0] rand_w();
    logic [N*WW-1:0] r;
    for (int i = 0; i < N; i++) r[i*WW +: WW] = WW'($urandom_range(0, (1 << WW) - 1));
    return r;
  endfunction

  function automatic logic [N*AW-1:0] rand_a();
    logic [N*AW-1:0] r;
    for (int i = 0; i < N; i++) r[i*AW +: AW] = AW'($urandom_range(0, (1 << AW) - 1));
    return r;
  endfunction

  // Reference dot product: plain sum of lane products.
  function automatic longint dot_of(input logic [N*WW-1:0] w, input logic [N*AW-1:0] a);
    longint s = 0;
    for (int i = 0; i < N; i++) s += longint'(w[i*WW +: WW]) * longint'(a[i*AW +: AW]);
    return s;
  endfunction

  // One full transaction: present, count edges to out_valid, capture, then hand off.
  task automatic run_vec(input logic [N*WW-1:0] w, input logic [N*AW-1:0] a, input logic clr,
                         output int lat, output logic [OW-1:0] o, output logic [OW2-1:0] o2);
    @(negedge CLK);
    weights = w; acts = a; acc_clear = clr; in_valid = 1'b1;
    @(posedge CLK); #1;
    in_valid = 1'b0;
    weights = rand_w(); acts = rand_a(); acc_clear = 1'($urandom_range(0, 1));
    lat = 0;
    while (out_valid !== 1'b1 && lat < 40) begin
      @(posedge CLK); #1;
      lat++;
      if (lat == 2) begin
        weights = rand_w(); acts = rand_a();
      end
    end
    o = out; o2 = out2;
    @(negedge CLK);
    out_ready = 1'b1;
    @(posedge CLK); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge CLK);
    #1;
    tests++; if (out !== '0) begin fails++; $display("FAIL reset_out: got %0d want 0", out); end
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
    tests++; if (out2 !== '0) begin fails++; $display("FAIL reset_out2: got %0d want 0", out2); end
    @(negedge CLK);
    reset_n = 1'b1;
    #1;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_directed();
    int lat;
    logic [OW-1:0] o;
    logic [OW2-1:0] o2;
    logic [N*WW-1:0] w;
    logic [N*AW-1:0] a;
    int exp_acc[3] = '{1680, 3360, 5040};
    int exp_wrap[3] = '{1680, 3360, 944};

    run_vec(all_w(7), all_a(15), 1'b1, lat, o, o2);
    tests++; if (lat != AW) begin fails++; $display("FAIL latency: got %0d want %0d", lat, AW); end
    tests++; if (o !== OW'(1680)) begin fails++; $display("FAIL all_max: got %0d want 1680", o); end

    for (int i = 0; i < N; i++) begin
      w[i*WW +: WW] = WW'(i % 8);
      a[i*AW +: AW] = AW'((i % 2 == 0) ? 1 : 0);
    end
    run_vec(w, a, 1'b1, lat, o, o2);
    tests++; if (o !== OW'(24)) begin fails++; $display("FAIL even_lanes: got %0d want 24", o); end

    for (int j = 0; j < 3; j++) begin
      run_vec(all_w(7), all_a(15), (j == 0), lat, o, o2);
      tests++; if (o !== OW'(exp_acc[j])) begin fails++; $display("FAIL accumulate_%0d: got %0d want %0d", j, o, exp_acc[j]); end
      tests++; if (o2 !== OW2'(exp_wrap[j])) begin fails++; $display("FAIL wrap_%0d: got %0d want %0d", j, o2, exp_wrap[j]); end
    end
  endtask

  task automatic test_random();
    int lat;
    logic [OW-1:0] o, exp_o;
    logic [OW2-1:0] o2, exp_o2;
    logic [N*WW-1:0] w;
    logic [N*AW-1:0] a;
    logic clr;
    longint d;
    exp_o = '0; exp_o2 = '0;
    for (int t = 0; t < 24; t++) begin
      clr = (t == 0) ? 1'b1 : 1'($urandom_range(0, 3) == 0);
      if (t % 5 == 4) begin
        w = all_w(7); a = all_a(15);
      end else begin
        w = rand_w(); a = rand_a();
      end
      d = dot_of(w, a);
      exp_o  = (clr ? '0 : exp_o) + OW'(d);
      exp_o2 = (clr ? '0 : exp_o2) + OW2'(d);
      run_vec(w, a, clr, lat, o, o2);
      tests++; if (lat != AW) begin fails++; $display("FAIL rand_latency_%0d: got %0d want %0d", t, lat, AW); end
      tests++; if (o !== exp_o) begin fails++; $display("FAIL rand_out_%0d: got %0d want %0d", t, o, exp_o); end
      tests++; if (o2 !== exp_o2) begin fails++; $display("FAIL rand_out2_%0d: got %0d want %0d", t, o2, exp_o2); end
    end
  endtask

  task automatic test_backpressure();
    int lat, n;
    logic [OW-1:0] o;
    logic [OW2-1:0] o2;
    @(negedge CLK);
    weights = all_w(7); acts = all_a(15); acc_clear = 1'b1; in_valid = 1'b1;
    @(posedge CLK); #1;
    in_valid = 1'b0;
    n = 0;
    while (out_valid !== 1'b1 && n < 40) begin
      @(posedge CLK); #1;
      n++;
    end
    tests++; if (n != AW) begin fails++; $display("FAIL bp_latency: got %0d want %0d", n, AW); end
    for (int c = 0; c < 5; c++) begin
      @(negedge CLK);
      in_valid = 1'($urandom_range(0, 1)) | (c == 0);
      weights = all_w(1); acts = all_a(1); acc_clear = 1'b1;
      @(posedge CLK); #1;
      tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL bp_valid_%0d: got %b want 1", c, out_valid); end
      tests++; if (out !== OW'(1680)) begin fails++; $display("FAIL bp_out_%0d: got %0d want 1680", c, out); end
      tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL bp_in_ready_%0d: got %b want 0", c, in_ready); end
    end
    @(negedge CLK);
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge CLK); #1;
    out_ready = 1'b0;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL bp_release_valid: got %b want 0", out_valid); end
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL bp_release_ready: got %b want 1", in_ready); end
    tests++; if (out !== OW'(1680)) begin fails++; $display("FAIL bp_hold_out: got %0d want 1680", out); end
    run_vec(all_w(1), all_a(1), 1'b0, lat, o, o2);
    tests++; if (o !== OW'(1696)) begin fails++; $display("FAIL bp_followup: got %0d want 1696", o); end
  endtask

  task automatic test_reset_mid();
    int lat;
    logic [OW-1:0] o;
    logic [OW2-1:0] o2;
    @(negedge CLK);
    weights = all_w(7); acts = all_a(15); acc_clear = 1'b1; in_valid = 1'b1;
    @(posedge CLK); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL mid_busy: got %b want 1", busy); end
    reset_n = 1'b0;
    #1;
    tests++; if (out !== '0) begin fails++; $display("FAIL mid_reset_out: got %0d want 0", out); end
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL mid_reset_valid: got %b want 0", out_valid); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL mid_reset_busy: got %b want 0", busy); end
    @(negedge CLK);
    reset_n = 1'b1;
    run_vec(all_w(1), all_a(1), 1'b0, lat, o, o2);
    tests++; if (lat != AW) begin fails++; $display("FAIL mid_next_latency: got %0d want %0d", lat, AW); end
    tests++; if (o !== OW'(16)) begin fails++; $display("FAIL mid_next_out: got %0d want 16", o); end
  endtask

  task automatic test_back_to_back();
    int times[$];
    logic [OW-1:0] vals[$];
    int n;
    @(negedge CLK);
    weights = all_w(1); acts = all_a(1); acc_clear = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(posedge CLK); #1;
      if (out_valid === 1'b1) begin
        times.push_back(c);
        vals.push_back(out);
      end
    end
    @(negedge CLK);
    in_valid = 1'b0;
    n = 0;
    while ((busy !== 1'b0 || out_valid !== 1'b0) && n < 20) begin
      @(posedge CLK); #1;
      n++;
    end
    out_ready = 1'b0;
    tests++; if (n >= 20) begin fails++; $display("FAIL b2b_drain: got busy=%b want 0", busy); end
    tests++; if (times.size() < 3) begin fails++; $display("FAIL b2b_count: got %0d want >=3", times.size()); end
    for (int j = 1; j < times.size(); j++) begin
      tests++; if (times[j] - times[j-1] != AW + 2) begin fails++; $display("FAIL b2b_period_%0d: got %0d want %0d", j, times[j] - times[j-1], AW + 2); end
    end
    for (int j = 0; j < vals.size(); j++) begin
      tests++; if (vals[j] !== OW'(16 + 16 * (j + 1))) begin fails++; $display("FAIL b2b_value_%0d: got %0d want %0d", j, vals[j], 16 + 16 * (j + 1)); end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
